lcd_pattern_ctrl: RTL and testbench

Test-pattern controller for the 800x480 RGB LCD path. It sits between the RGB timing generator (which supplies vs/de/x/y) and the panel data pins.
- Sequences panel power-up: holds the backlight off and output black for a fixed number of frames.
- Selects one of 8 test patterns from a debounced key or an auto-cycle timer.
- Applies pattern changes only at frame boundaries, so a frame never tears.

---
 rtl/lcd_pkg.sv | 73 +++++++
 rtl/lcd_pattern_ctrl_if.sv | 24 ++
 rtl/key_debounce.sv | 44 ++++
 rtl/lcd_pattern_ctrl.sv | 118 +++++++++++
 tb/tb_lcd_pattern_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared types, color constants and the per-pixel pattern decode
// for the LCD test-pattern controller.
package lcd_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 480;
  localparam int BAR_W        = 100;

  typedef enum logic [2:0] {
    PAT_WHITE,
    PAT_RED,
    PAT_GREEN,
    PAT_BLUE,
    PAT_BARS,
    PAT_CHECKER,
    PAT_GRAY,
    PAT_BORDER
  } pattern_e;

  typedef enum logic {
    S_BLANK,
    S_RUN
  } state_e;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  // Left-to-right order of the eight vertical color bars.
  localparam logic [23:0] BAR_COLORS [8] = '{
    COL_WHITE, COL_YELLOW, COL_CYAN, COL_GREEN,
    COL_MAGENTA, COL_RED, COL_BLUE, COL_BLACK
  };

  function automatic logic [23:0] pattern_color(
    input pattern_e    pat,
    input logic [10:0] x,
    input logic [10:0] y,
    input int          h_act,
    input int          v_act
  );
    logic [23:0] color;
    logic [2:0]  bar;
    color = COL_BLACK;
    bar   = '0;
    case (pat)
      PAT_WHITE:   color = COL_WHITE;
      PAT_RED:     color = COL_RED;
      PAT_GREEN:   color = COL_GREEN;
      PAT_BLUE:    color = COL_BLUE;
      PAT_BARS: begin
        for (int k = 1; k < 8; k++) begin
          if (x >= 11'(k * BAR_W)) bar = 3'(k);
        end
        color = BAR_COLORS[bar];
      end
      PAT_CHECKER: color = (x[5] ^ y[5]) ? COL_WHITE : COL_BLACK;
      PAT_GRAY:    color = {x[9:2], x[9:2], x[9:2]};
      PAT_BORDER: begin
        if (x == '0 || x == 11'(h_act - 1) || y == '0 || y == 11'(v_act - 1))
          color = COL_WHITE;
      end
      default:     color = COL_BLACK;
    endcase
    return color;
  endfunction

endpackage

// File: rtl/lcd_pattern_ctrl_if.sv
// Pixel-path bundle between the timing generator / key inputs and the
// pattern controller.
interface lcd_pattern_ctrl_if;
  logic        i_key_n;
  logic        i_auto_en;
  logic        i_rgb_vs;
  logic        i_rgb_de;
  logic [10:0] i_rgb_x;
  logic [10:0] i_rgb_y;
  logic [23:0] o_rgb_data;
  logic        o_bl_en;
  logic [2:0]  o_pattern;
  logic        o_running;

  modport slave (
    input  i_key_n, i_auto_en, i_rgb_vs, i_rgb_de, i_rgb_x, i_rgb_y,
    output o_rgb_data, o_bl_en, o_pattern, o_running
  );

  modport master (
    output i_key_n, i_auto_en, i_rgb_vs, i_rgb_de, i_rgb_x, i_rgb_y,
    input  o_rgb_data, o_bl_en, o_pattern, o_running
  );
endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-time debounce and a
// one-cycle pulse on each debounced press (high->low).
module key_debounce #(
  parameter int DB_CYCLES = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_press
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]    r_sync;
  logic          r_db;
  logic          r_db_d;
  logic [CW-1:0] r_cnt;
  logic          w_sync;

  assign w_sync = r_sync[1];

  // Idle level is released (high) so reset never looks like a press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b11;
      r_db   <= 1'b1;
      r_db_d <= 1'b1;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_key_n};
      r_db_d <= r_db;
      if (w_sync == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
        r_db  <= w_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_db_d & ~r_db;

endmodule

// File: rtl/lcd_pattern_ctrl.sv
// Test-pattern controller: power-up blanking, key / auto pattern select
// applied only at frame start, and registered per-pixel pattern decode.
module lcd_pattern_ctrl
  import lcd_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 33_000_000,
  parameter int DEBOUNCE_MS  = 20,
  parameter int PWRUP_FRAMES = 4,
  parameter int AUTO_FRAMES  = 120,
  parameter int NUM_PATTERNS = 8,
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF
) (
  input logic          i_rgb_clk,
  input logic          i_rgb_rst_n,
  lcd_pattern_ctrl_if.slave bus
);
  localparam int DB_CYCLES = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int FW = (PWRUP_FRAMES > 1) ? $clog2(PWRUP_FRAMES) : 1;
  localparam int AW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

  state_e        r_state,     w_state_next;
  pattern_e      r_pattern,   w_pattern_next;
  logic [FW-1:0] r_frame_cnt, w_frame_next;
  logic [AW-1:0] r_auto_cnt,  w_auto_next;
  logic          r_pending,   w_pending_next;
  logic          r_vs;
  logic [23:0]   r_rgb_data;
  logic          w_press;
  logic          w_fs;
  logic          w_advance;

  key_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_key_debounce (
    .i_clk   (i_rgb_clk),
    .i_rst_n (i_rgb_rst_n),
    .i_key_n (bus.i_key_n),
    .o_press (w_press)
  );

  // r_vs resets low so the first cycle after reset can never be a frame start.
  assign w_fs = r_vs & ~bus.i_rgb_vs;

  always_ff @(posedge i_rgb_clk or negedge i_rgb_rst_n) begin
    if (!i_rgb_rst_n) begin
      r_state     <= S_BLANK;
      r_pattern   <= PAT_WHITE;
      r_frame_cnt <= '0;
      r_auto_cnt  <= '0;
      r_pending   <= 1'b0;
      r_vs        <= 1'b0;
      r_rgb_data  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pattern   <= w_pattern_next;
      r_frame_cnt <= w_frame_next;
      r_auto_cnt  <= w_auto_next;
      r_pending   <= w_pending_next;
      r_vs        <= bus.i_rgb_vs;
      r_rgb_data  <= (r_state == S_RUN && bus.i_rgb_de)
                     ? pattern_color(r_pattern, bus.i_rgb_x, bus.i_rgb_y, H_ACTIVE, V_ACTIVE)
                     : '0;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pattern_next = r_pattern;
    w_frame_next   = r_frame_cnt;
    w_auto_next    = r_auto_cnt;
    w_pending_next = r_pending;
    w_advance      = 1'b0;
    case (r_state)
      S_BLANK: begin
        if (w_fs) begin
          if (r_frame_cnt == FW'(PWRUP_FRAMES - 1)) begin
            w_state_next = S_RUN;
            w_frame_next = '0;
          end else begin
            w_frame_next = r_frame_cnt + FW'(1);
          end
        end
      end
      S_RUN: begin
        // A press landing on the frame-start cycle counts as already pending.
        if (w_fs) begin
          if (r_pending || w_press) begin
            w_advance      = 1'b1;
            w_pending_next = 1'b0;
            w_auto_next    = '0;
          end else if (bus.i_auto_en && AUTO_FRAMES != 0) begin
            if (r_auto_cnt == AW'(AUTO_FRAMES - 1)) begin
              w_advance   = 1'b1;
              w_auto_next = '0;
            end else begin
              w_auto_next = r_auto_cnt + AW'(1);
            end
          end
        end else if (w_press) begin
          w_pending_next = 1'b1;
        end
        if (!bus.i_auto_en) w_auto_next = '0;
      end
      default: w_state_next = S_BLANK;
    endcase
    if (w_advance) begin
      w_pattern_next = (r_pattern == 3'(NUM_PATTERNS - 1))
                       ? PAT_WHITE : pattern_e'(r_pattern + 3'd1);
    end
  end

  assign bus.o_rgb_data = r_rgb_data;
  assign bus.o_bl_en    = (r_state == S_RUN);
  assign bus.o_running  = (r_state == S_RUN);
  assign bus.o_pattern  = r_pattern;

endmodule

// File: tb/tb_lcd_pattern_ctrl.sv
// Directed bench for lcd_pattern_ctrl: power-up, key debounce, frame-aligned
// pattern changes, auto-cycle and pixel decode.
module tb_lcd_pattern_ctrl;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  lcd_pattern_ctrl_if bus ();

  lcd_pattern_ctrl #(
    .CLK_FREQ_HZ  (1_000_000),
    .DEBOUNCE_MS  (1),
    .PWRUP_FRAMES (2),
    .AUTO_FRAMES  (3),
    .NUM_PATTERNS (8),
    .H_ACTIVE     (800),
    .V_ACTIVE     (480)
  ) dut (
    .i_rgb_clk   (clk),
    .i_rgb_rst_n (rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic frame_start();
    bus.i_rgb_vs = 1'b0;
    step(1);
    bus.i_rgb_vs = 1'b1;
    step(1);
  endtask

  task automatic press();
    bus.i_key_n = 1'b0;
    step(1010);
    bus.i_key_n = 1'b1;
    step(1010);
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic de,
                     input logic [23:0] exp);
    bus.i_rgb_x  = 11'(x);
    bus.i_rgb_y  = 11'(y);
    bus.i_rgb_de = de;
    step(1);
    check(tag, {8'h0, bus.o_rgb_data}, {8'h0, exp});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n         = 1'b0;
    bus.i_key_n   = 1'b1;
    bus.i_auto_en = 1'b0;
    bus.i_rgb_vs  = 1'b1;
    bus.i_rgb_de  = 1'b1;
    bus.i_rgb_x   = 11'd10;
    bus.i_rgb_y   = 11'd10;
    step(3);
    check("rst_data", {8'h0, bus.o_rgb_data}, 32'h0);
    check("rst_bl", 32'(bus.o_bl_en), 32'h0);
    check("rst_pat", 32'(bus.o_pattern), 32'h0);
    check("rst_run", 32'(bus.o_running), 32'h0);
    rst_n = 1'b1;
    step(2);

    // Power-up: a press while blanking must be dropped.
    press();
    check("blank_bl", 32'(bus.o_bl_en), 32'h0);
    check("blank_data", {8'h0, bus.o_rgb_data}, 32'h0);
    frame_start();
    check("fs1_bl", 32'(bus.o_bl_en), 32'h0);
    check("fs1_run", 32'(bus.o_running), 32'h0);
    check("fs1_data", {8'h0, bus.o_rgb_data}, 32'h0);
    frame_start();
    check("fs2_bl", 32'(bus.o_bl_en), 32'h1);
    check("fs2_run", 32'(bus.o_running), 32'h1);
    check("fs2_pat", 32'(bus.o_pattern), 32'h0);
    check("fs2_data", {8'h0, bus.o_rgb_data}, 32'h00FFFFFF);
    frame_start();
    check("blank_press_dropped", 32'(bus.o_pattern), 32'h0);

    // Bouncy press then long hold: exactly one advance, only at next fs.
    for (int i = 0; i < 5; i++) begin
      bus.i_key_n = 1'b0;
      step(100);
      bus.i_key_n = 1'b1;
      step(50);
    end
    bus.i_key_n = 1'b0;
    step(1500);
    check("bounce_pre_fs_pat", 32'(bus.o_pattern), 32'h0);
    check("bounce_pre_fs_data", {8'h0, bus.o_rgb_data}, 32'h00FFFFFF);
    bus.i_key_n = 1'b1;
    step(1100);
    frame_start();
    check("bounce_fs_pat", 32'(bus.o_pattern), 32'h1);
    check("bounce_fs_data", {8'h0, bus.o_rgb_data}, 32'h00FF0000);
    frame_start();
    check("bounce_single", 32'(bus.o_pattern), 32'h1);

    // Three presses in one frame collapse to one advance.
    press();
    press();
    press();
    check("multi_pre_fs", 32'(bus.o_pattern), 32'h1);
    frame_start();
    check("multi_fs_pat", 32'(bus.o_pattern), 32'h2);
    check("multi_fs_data", {8'h0, bus.o_rgb_data}, 32'h0000FF00);

    // Press pulse lands on the 1003rd edge after the key falls; align fs to it.
    bus.i_key_n = 1'b0;
    step(1002);
    bus.i_rgb_vs = 1'b0;
    step(1);
    check("coinc_fs_pat", 32'(bus.o_pattern), 32'h3);
    bus.i_rgb_vs = 1'b1;
    step(1);
    bus.i_key_n = 1'b1;
    step(1010);
    frame_start();
    check("coinc_no_repeat", 32'(bus.o_pattern), 32'h3);
    check("coinc_data", {8'h0, bus.o_rgb_data}, 32'h000000FF);

    // Auto-cycle: advance every 3rd fs, wrapping 7 -> 0.
    bus.i_auto_en = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      frame_start();
      check($sformatf("auto_fs%0d", i), 32'(bus.o_pattern), 32'((3 + i / 3) % 8));
    end
    frame_start();
    frame_start();
    check("auto_cnt2", 32'(bus.o_pattern), 32'h0);
    press();
    frame_start();
    check("auto_key_adv", 32'(bus.o_pattern), 32'h1);
    frame_start();
    frame_start();
    check("auto_cnt_cleared", 32'(bus.o_pattern), 32'h1);
    frame_start();
    check("auto_after_key", 32'(bus.o_pattern), 32'h2);
    bus.i_auto_en = 1'b0;

    // Pixel decode of the structured patterns.
    press();
    frame_start();
    press();
    frame_start();
    check("pat4", 32'(bus.o_pattern), 32'h4);
    pix("bars_x99", 99, 0, 1'b1, 24'hFFFFFF);
    pix("bars_x100", 100, 0, 1'b1, 24'hFFFF00);
    pix("bars_x250", 250, 0, 1'b1, 24'h00FFFF);
    pix("bars_x799", 799, 0, 1'b1, 24'h000000);
    press();
    frame_start();
    check("pat5", 32'(bus.o_pattern), 32'h5);
    pix("chk_32_0", 32, 0, 1'b1, 24'hFFFFFF);
    pix("chk_32_32", 32, 32, 1'b1, 24'h000000);
    press();
    frame_start();
    check("pat6", 32'(bus.o_pattern), 32'h6);
    pix("gray_x799", 799, 0, 1'b1, 24'hC7C7C7);
    press();
    frame_start();
    check("pat7", 32'(bus.o_pattern), 32'h7);
    pix("border_0_5", 0, 5, 1'b1, 24'hFFFFFF);
    pix("border_5_5", 5, 5, 1'b1, 24'h000000);
    pix("border_799_5", 799, 5, 1'b1, 24'hFFFFFF);
    pix("border_5_479", 5, 479, 1'b1, 24'hFFFFFF);
    pix("border_de0", 0, 5, 1'b0, 24'h000000);

    // Asynchronous reset mid-frame clears outputs without waiting for a clock edge.
    bus.i_rgb_de = 1'b1;
    step(2);
    check("pre_rst_data", {8'h0, bus.o_rgb_data}, 32'h00FFFFFF);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_data", {8'h0, bus.o_rgb_data}, 32'h0);
    check("mid_rst_bl", 32'(bus.o_bl_en), 32'h0);
    check("mid_rst_pat", 32'(bus.o_pattern), 32'h0);
    check("mid_rst_run", 32'(bus.o_running), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    frame_start();
    check("post_rst_bl", 32'(bus.o_bl_en), 32'h0);
    check("post_rst_data", {8'h0, bus.o_rgb_data}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
